// File: rtl/risc_ctrl_seq.sv
// risc_ctrl_seq: multi-cycle fetch/decode/execute sequencer feeding an 8-bit ALU.
// Holds the PC, instruction register, a 4-entry register file and the zero flag.
//
// Ports:
//   Clk, Rst          rising-edge clock, asynchronous active-high reset
//   Start             begin execution at PC=0 (accepted only in IDLE or HALT)
//   Instr_addr        fetch address, always equal to the PC
//   Instr_rd          fetch request, high throughout FETCH
//   Instr_data        fetched instruction
//   Instr_vld         Instr_data valid, sampled only in FETCH
//   Alu_in1, Alu_in2  registered ALU operands, loaded at DECODE->EXEC
//   Alu_sel           ALU operation, non-zero only in EXEC of ops 0x1..0x7
//   Alu_out           ALU result (combinational return)
//   Alu_zero_flg      ALU zero flag (combinational return)
//   Busy              high in FETCH, DECODE, EXEC
//   Halted            high in HALT
//   Illegal           one-cycle pulse in EXEC for opcodes 0xC..0xF
//   dbg_state         current FSM state: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 HALT
//
// Fetch handshake: Instr_rd is the request and stays high with Instr_addr
// stable for as long as the FSM sits in FETCH; the instruction transfers on
// the rising edge where Instr_rd and Instr_vld are both high. Instr_vld has
// no effect in any other state.
module risc_ctrl_seq #(
  parameter int wrd_size    = 8,
  parameter int sel_width   = 3,
  parameter int addr_width  = 8,
  parameter int instr_width = 12
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  output logic [addr_width-1:0]  Instr_addr,
  output logic                   Instr_rd,
  input  logic [instr_width-1:0] Instr_data,
  input  logic                   Instr_vld,
  output logic [wrd_size-1:0]    Alu_in1,
  output logic [wrd_size-1:0]    Alu_in2,
  output logic [sel_width-1:0]   Alu_sel,
  input  logic [wrd_size-1:0]    Alu_out,
  input  logic                   Alu_zero_flg,
  output logic                   Busy,
  output logic                   Halted,
  output logic                   Illegal,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t                 state, next_state;
  logic [addr_width-1:0]  pc;
  logic [instr_width-1:0] ir;
  logic [wrd_size-1:0]    rf [4];
  logic                   z;

  logic [3:0] op;
  logic [1:0] ra, rb;
  logic       is_alu;

  assign op     = ir[11:8];
  assign ra     = ir[7:6];
  assign rb     = ir[5:4];
  assign is_alu = (op != 4'h0) && !op[3];

  assign Instr_addr = pc;
  assign dbg_state  = state;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    Instr_rd   = 1'b0;
    Busy       = 1'b0;
    Halted     = 1'b0;
    Illegal    = 1'b0;
    Alu_sel    = '0;
    case (state)
      IDLE: begin
        if (Start) next_state = FETCH;
      end
      FETCH: begin
        Instr_rd = 1'b1;
        Busy     = 1'b1;
        if (Instr_vld) next_state = DECODE;
      end
      DECODE: begin
        Busy       = 1'b1;
        next_state = EXEC;
      end
      EXEC: begin
        Busy = 1'b1;
        if (is_alu) Alu_sel = sel_width'(op[2:0]);
        // EXEC lasts exactly one cycle, so this is inherently a single pulse.
        if (op >= 4'hC) Illegal = 1'b1;
        next_state = (op == 4'hB) ? HALT : FETCH;
      end
      HALT: begin
        Halted = 1'b1;
        if (Start) next_state = FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: every architectural update is tied to leaving a particular
  // state, so an asynchronous reset can never leave a half-done write-back.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc      <= '0;
      ir      <= '0;
      z       <= 1'b0;
      Alu_in1 <= '0;
      Alu_in2 <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (Start) pc <= '0;
        end
        FETCH: begin
          if (Instr_vld) begin
            ir <= Instr_data;
            pc <= pc + 1'b1;
          end
        end
        DECODE: begin
          Alu_in1 <= rf[ra];
          Alu_in2 <= rf[rb];
        end
        EXEC: begin
          case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
              rf[ra] <= Alu_out;
              z      <= Alu_zero_flg;
            end
            4'h8: rf[ra] <= wrd_size'(ir[5:0]);
            4'h9: pc <= addr_width'(ir[7:0]);
            // Branch sees the flag as it stood before this edge.
            4'hA: if (z) pc <= addr_width'(ir[7:0]);
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// tb_risc_ctrl_seq: bench for risc_ctrl_seq with an instruction memory
// responder, a combinational ALU model and an instruction-level reference model.
module tb_risc_ctrl_seq;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Instr_addr;
  logic        Instr_rd;
  logic [11:0] Instr_data = 12'h000;
  logic        Instr_vld = 1'b0;
  logic [7:0]  Alu_in1, Alu_in2;
  logic [2:0]  Alu_sel;
  logic [7:0]  Alu_out;
  logic        Alu_zero_flg;
  logic        Busy, Halted, Illegal;
  logic [2:0]  dbg_state;

  risc_ctrl_seq dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .Instr_addr(Instr_addr), .Instr_rd(Instr_rd),
    .Instr_data(Instr_data), .Instr_vld(Instr_vld),
    .Alu_in1(Alu_in1), .Alu_in2(Alu_in2), .Alu_sel(Alu_sel),
    .Alu_out(Alu_out), .Alu_zero_flg(Alu_zero_flg),
    .Busy(Busy), .Halted(Halted), .Illegal(Illegal),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  logic [11:0] mem [256];
  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  logic [7:0]  exp_fetch[$];
  logic [7:0]  obs_fetch[$];
  int          obs_ill = 0;
  int          exp_ill = 0;
  int          sel_viol = 0;
  int          in_viol = 0;

  logic [7:0]  m_rf [4];
  logic        m_z;
  logic [7:0]  m_pc;

  int fixed_stall = 0;
  bit rand_stall  = 1'b0;
  bit noise_en    = 1'b0;
  int wait_left   = 0;

  // ---------------- ALU model ----------------
  function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    case (sel)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a << b;
      3'd6: return a >> b;
      3'd7: return ~a;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] alu_res;
  always_comb alu_res = alu_f(Alu_sel, Alu_in1, Alu_in2);
  assign Alu_out      = alu_res;
  assign Alu_zero_flg = (alu_res == 8'h00);

  // ---------------- instruction memory responder ----------------
  always @(negedge Clk) begin
    if (Instr_rd) begin
      if (wait_left > 0) begin
        Instr_vld  = 1'b0;
        Instr_data = 12'($urandom);
        wait_left  = wait_left - 1;
      end else begin
        Instr_vld  = 1'b1;
        Instr_data = mem[Instr_addr];
        obs_fetch.push_back(Instr_addr);
      end
    end else begin
      Instr_vld  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      Instr_data = 12'($urandom);
      wait_left  = rand_stall ? int'($urandom_range(0, 3)) : fixed_stall;
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] prev_in1 = 8'h00;
  logic [7:0] prev_in2 = 8'h00;
  logic [2:0] prev_st  = 3'd0;
  always @(negedge Clk) begin
    if (Alu_sel != 3'b000) obs_q.push_back({Alu_sel, Alu_in1, Alu_in2});
    if (Illegal) obs_ill = obs_ill + 1;
    if (Alu_sel != 3'b000 && dbg_state != 3'd3) sel_viol = sel_viol + 1;
    if ((Alu_in1 !== prev_in1 || Alu_in2 !== prev_in2) && !(prev_st == 3'd2 && dbg_state == 3'd3))
      in_viol = in_viol + 1;
    prev_in1 = Alu_in1;
    prev_in2 = Alu_in2;
    prev_st  = dbg_state;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 12'hB00;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_fetch.delete();
    obs_ill  = 0;
    sel_viol = 0;
    in_viol  = 0;
  endtask

  task automatic do_reset();
    Rst   = 1'b1;
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_z = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (Halted) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic run_prog(output bit ok);
    clear_obs();
    pulse_start();
    wait_halt(ok);
  endtask

  // Instruction-level model: executes mem from PC 0 until HLT.
  task automatic run_model();
    logic [7:0]  pc, a, b, r;
    logic [11:0] ins;
    logic [3:0]  op;
    logic [1:0]  ra, rb;
    bit          done;
    exp_q.delete();
    exp_fetch.delete();
    exp_ill = 0;
    pc = 8'h00;
    done = 1'b0;
    for (int s = 0; s < 500 && !done; s++) begin
      exp_fetch.push_back(pc);
      ins = mem[pc];
      pc  = pc + 8'd1;
      op = ins[11:8];
      ra = ins[7:6];
      rb = ins[5:4];
      if (op >= 4'h1 && op <= 4'h7) begin
        a = m_rf[ra];
        b = m_rf[rb];
        r = alu_f(op[2:0], a, b);
        exp_q.push_back({op[2:0], a, b});
        m_rf[ra] = r;
        m_z = (r == 8'h00);
      end else if (op == 4'h8) m_rf[ra] = {2'b00, ins[5:0]};
      else if (op == 4'h9) pc = ins[7:0];
      else if (op == 4'hA) begin
        if (m_z) pc = ins[7:0];
      end else if (op == 4'hB) done = 1'b1;
      else if (op >= 4'hC) exp_ill++;
    end
    m_pc = pc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit found;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    total++; if ({Instr_rd, Busy, Halted, Illegal} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {Instr_rd, Busy, Halted, Illegal}); end
    total++; if ({Instr_addr, Alu_sel, Alu_in1, Alu_in2} !== 27'd0) begin bad++; $display("FAIL rst_outputs got=%h exp=0", {Instr_addr, Alu_sel, Alu_in1, Alu_in2}); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end

    clear_mem();
    mem[0] = 12'h845;            // LDI R1,5
    fixed_stall = 6;
    Rst = 1'b0;
    @(negedge Clk);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (Instr_rd && Instr_addr == 8'h01) begin found = 1'b1; break; end
      @(negedge Clk);
    end
    total++; if (!found) begin bad++; $display("FAIL rst_reach_fetch got=timeout exp=fetch_at_1"); end
    total++; if (dut.rf[1] !== 8'h05) begin bad++; $display("FAIL rst_pre_r1 got=%0h exp=05", dut.rf[1]); end
    #2 Rst = 1'b1;
    #1;
    total++; if ({Instr_rd, Busy} !== 2'b00) begin bad++; $display("FAIL rst_mid_flags got=%b exp=00", {Instr_rd, Busy}); end
    total++; if (Instr_addr !== 8'h00 || Alu_sel !== 3'b000) begin bad++; $display("FAIL rst_mid_pc_sel got=%0h/%0h exp=0/0", Instr_addr, Alu_sel); end
    total++; if (dut.rf[1] !== 8'h00) begin bad++; $display("FAIL rst_mid_r1 got=%0h exp=00", dut.rf[1]); end
    @(negedge Clk);
    Rst = 1'b0;
    fixed_stall = 0;
    repeat (3) @(negedge Clk);
    total++; if ({Instr_rd, Busy, Halted} !== 3'b000 || dbg_state !== 3'd0) begin bad++; $display("FAIL rst_post_idle got=%b st=%0d exp=000 st=0", {Instr_rd, Busy, Halted}, dbg_state); end
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_z = 1'b0;
  endtask

  task automatic test_sub();
    bit ok;
    clear_mem();
    mem[0] = 12'h845;  // LDI R1,5
    mem[1] = 12'h883;  // LDI R2,3
    mem[2] = 12'h260;  // SUB R1,R2
    mem[3] = 12'hB00;  // HLT
    run_prog(ok);
    total++; if (!ok) begin bad++; $display("FAIL sub_halt got=timeout exp=halted"); end
    total++; if (dut.rf[1] !== 8'h02) begin bad++; $display("FAIL sub_r1 got=%0h exp=02", dut.rf[1]); end
    total++; if (dut.z !== 1'b0) begin bad++; $display("FAIL sub_z got=%b exp=0", dut.z); end
    total++; if (Halted !== 1'b1 || Instr_addr !== 8'h04) begin bad++; $display("FAIL sub_pc got=%b/%0h exp=1/04", Halted, Instr_addr); end
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL sub_sel_cycles got=%0d exp=1", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== {3'b010, 8'd5, 8'd3}) begin bad++; $display("FAIL sub_alu_ops got=%h exp=%h", obs_q[0], {3'b010, 8'd5, 8'd3}); end
    end
    total++; if (sel_viol != 0 || in_viol != 0) begin bad++; $display("FAIL sub_alu_timing got=%0d/%0d exp=0/0", sel_viol, in_viol); end
  endtask

  task automatic test_bz();
    bit ok;
    logic [7:0] ef[$];
    clear_mem();
    mem[0]     = 12'h807;  // LDI R0,7
    mem[1]     = 12'h8C7;  // LDI R3,7
    mem[2]     = 12'h230;  // SUB R0,R3
    mem[3]     = 12'hA10;  // BZ 0x10
    mem[4]     = 12'h000;  // NOP (fall-through would halt at 0x06)
    mem[8'h10] = 12'hB00;  // HLT
    ef = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10};
    run_prog(ok);
    total++; if (!ok) begin bad++; $display("FAIL bz_halt got=timeout exp=halted"); end
    total++; if (dut.rf[0] !== 8'h00 || dut.z !== 1'b1) begin bad++; $display("FAIL bz_r0_z got=%0h/%b exp=00/1", dut.rf[0], dut.z); end
    total++; if (Instr_addr !== 8'h11) begin bad++; $display("FAIL bz_pc got=%0h exp=11", Instr_addr); end
    total++; if (obs_fetch.size() != ef.size()) begin bad++; $display("FAIL bz_fetch_len got=%0d exp=%0d", obs_fetch.size(), ef.size()); end
    else for (int i = 0; i < ef.size(); i++) begin
      total++; if (obs_fetch[i] !== ef[i]) begin bad++; $display("FAIL bz_fetch_%0d got=%0h exp=%0h", i, obs_fetch[i], ef[i]); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_mem();
    mem[0] = 12'h849;  // LDI R1,9
    mem[1] = 12'hB00;
    fixed_stall = 4;
    clear_obs();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge Clk);
      total++; if (Instr_rd !== 1'b1 || Instr_addr !== 8'h00 || dbg_state !== 3'd1) begin bad++; $display("FAIL stall_hold_%0d got=rd%b addr%0h st%0d exp=rd1 addr0 st1", k, Instr_rd, Instr_addr, dbg_state); end
    end
    @(posedge Clk);
    #1;
    total++; if (dut.ir !== 12'h849 || dbg_state !== 3'd2 || Instr_addr !== 8'h01) begin bad++; $display("FAIL stall_load got=ir%0h st%0d pc%0h exp=ir849 st2 pc1", dut.ir, dbg_state, Instr_addr); end
    wait_halt(ok);
    fixed_stall = 0;
    total++; if (!ok || dut.rf[1] !== 8'h09) begin bad++; $display("FAIL stall_result got=%b/%0h exp=1/09", ok, dut.rf[1]); end
  endtask

  task automatic test_wrap_restart();
    bit ok, left;
    logic [7:0] ef[$];
    do_reset();
    clear_mem();
    mem[0]     = 12'h855;  // LDI R1,0x15
    mem[1]     = 12'h9FF;  // JMP 0xFF
    mem[8'hFF] = 12'h000;  // NOP
    ef = '{8'h00, 8'h01, 8'hFF, 8'h00};
    clear_obs();
    pulse_start();
    left = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (!Instr_rd) begin left = 1'b1; break; end
    end
    total++; if (!left) begin bad++; $display("FAIL wrap_first_fetch got=timeout exp=decode"); end
    mem[0] = 12'hB00;      // address 0 now holds HLT for the wrapped fetch
    wait_halt(ok);
    total++; if (!ok || Instr_addr !== 8'h01) begin bad++; $display("FAIL wrap_pc got=%b/%0h exp=1/01", ok, Instr_addr); end
    total++; if (obs_fetch.size() != ef.size()) begin bad++; $display("FAIL wrap_fetch_len got=%0d exp=%0d", obs_fetch.size(), ef.size()); end
    else for (int i = 0; i < ef.size(); i++) begin
      total++; if (obs_fetch[i] !== ef[i]) begin bad++; $display("FAIL wrap_fetch_%0d got=%0h exp=%0h", i, obs_fetch[i], ef[i]); end
    end
    mem[0] = 12'h8C1;      // LDI R3,1
    mem[1] = 12'hB00;
    run_prog(ok);
    total++; if (!ok || Instr_addr !== 8'h02) begin bad++; $display("FAIL restart_pc got=%b/%0h exp=1/02", ok, Instr_addr); end
    total++; if (dut.rf[1] !== 8'h15 || dut.rf[3] !== 8'h01 || dut.rf[0] !== 8'h00) begin bad++; $display("FAIL restart_regs got=%0h/%0h/%0h exp=15/01/00", dut.rf[1], dut.rf[3], dut.rf[0]); end
  endtask

  task automatic test_illegal();
    bit ok;
    clear_mem();
    mem[0] = 12'h843;  // LDI R1,3
    mem[1] = 12'h250;  // SUB R1,R1 -> 0, Z=1
    mem[2] = 12'hDFF;  // undefined
    mem[3] = 12'h884;  // LDI R2,4
    mem[4] = 12'hB00;
    run_prog(ok);
    total++; if (!ok || Instr_addr !== 8'h05) begin bad++; $display("FAIL ill_pc got=%b/%0h exp=1/05", ok, Instr_addr); end
    total++; if (obs_ill != 1) begin bad++; $display("FAIL ill_pulse got=%0d exp=1", obs_ill); end
    total++; if (dut.rf[1] !== 8'h00 || dut.rf[2] !== 8'h04 || dut.rf[3] !== 8'h01) begin bad++; $display("FAIL ill_regs got=%0h/%0h/%0h exp=00/04/01", dut.rf[1], dut.rf[2], dut.rf[3]); end
    total++; if (dut.z !== 1'b1) begin bad++; $display("FAIL ill_z got=%b exp=1", dut.z); end
  endtask

  task automatic test_random();
    bit ok;
    int len;
    logic [3:0] op;
    logic [7:0] lo;
    do_reset();
    rand_stall = 1'b1;
    noise_en   = 1'b1;
    for (int it = 0; it < 25; it++) begin
      clear_mem();
      len = int'($urandom_range(3, 12));
      for (int i = 0; i < len; i++) begin
        op = 4'($urandom_range(0, 15));
        lo = 8'($urandom);
        if (op == 4'h9 || op == 4'hA) lo = 8'(i + int'($urandom_range(1, 3)));
        mem[i] = {op, lo};
      end
      run_model();
      run_prog(ok);
      total++; if (!ok) begin bad++; $display("FAIL rnd%0d_halt got=timeout exp=halted", it); end
      for (int i = 0; i < 4; i++) begin
        total++; if (dut.rf[i] !== m_rf[i]) begin bad++; $display("FAIL rnd%0d_r%0d got=%0h exp=%0h", it, i, dut.rf[i], m_rf[i]); end
      end
      total++; if (dut.z !== m_z) begin bad++; $display("FAIL rnd%0d_z got=%b exp=%b", it, dut.z, m_z); end
      total++; if (Instr_addr !== m_pc) begin bad++; $display("FAIL rnd%0d_pc got=%0h exp=%0h", it, Instr_addr, m_pc); end
      total++; if (obs_ill != exp_ill) begin bad++; $display("FAIL rnd%0d_illegal got=%0d exp=%0d", it, obs_ill, exp_ill); end
      total++; if (sel_viol != 0 || in_viol != 0) begin bad++; $display("FAIL rnd%0d_alu_timing got=%0d/%0d exp=0/0", it, sel_viol, in_viol); end
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_alu_len got=%0d exp=%0d", it, obs_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_alu_%0d got=%h exp=%h", it, i, obs_q[i], exp_q[i]); end
      end
      total++; if (obs_fetch.size() != exp_fetch.size()) begin bad++; $display("FAIL rnd%0d_fetch_len got=%0d exp=%0d", it, obs_fetch.size(), exp_fetch.size()); end
      else for (int i = 0; i < exp_fetch.size(); i++) begin
        total++; if (obs_fetch[i] !== exp_fetch[i]) begin bad++; $display("FAIL rnd%0d_fetch_%0d got=%0h exp=%0h", it, i, obs_fetch[i], exp_fetch[i]); end
      end
    end
    rand_stall = 1'b0;
    noise_en   = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_mem();
    test_reset();
    test_sub();
    test_bz();
    test_stall();
    test_wrap_restart();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
